ddr_wr_burst_ctrl: RTL and testbench
====================================

Name: ddr_wr_burst_ctrl

Overview:
- Frame-write scheduler on the DDR side of the camera-to-DDR path.
- Drains the 128-bit prefetch write FIFO (rd_vld/rd_en interface) into AXI3/4 write bursts.
- Places each frame into one of two DDR banks (ping-pong) and reports the last fully written bank to the HDMI read scheduler.
- Runs entirely in the FIFO read / DDR core clock domain.

Parameters:
- ADDR_W, 28, AXI byte-address width.
- DATA_W, 128, FIFO read width and AXI data width; beat size = DATA_W/8 bytes.
- BURST_LEN, 16, max beats per burst (1..256).
- FRAME_BEATS, 98304, beats per frame (1024x768x16bpp / 128).
- BASE_ADDR, 0, byte address of bank 0.
- BANK_STRIDE, 28'h0200000, byte offset of bank 1 from bank 0.

Ports:
- rd_clk  in  1  DDR core clock; also the FIFO read clock.
- rd_rst  in  1  Asynchronous, active-high reset.
- frame_start  in  1  One-cycle pulse, already synchronised to rd_clk: a new frame is entering the FIFO.
- fifo_rd_vld  in  1  FIFO head word valid.
- fifo_rd_data  in  DATA_W  FIFO head word.
- fifo_rd_en  out  1  Pops the FIFO head.
- m_awaddr  out  ADDR_W; m_awlen  out  8; m_awvalid  out  1; m_awready  in  1.
- m_wdata  out  DATA_W; m_wstrb  out  DATA_W/8; m_wlast  out  1; m_wvalid  out  1; m_wready  in  1.
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1.
- busy  out  1  Frame in progress.
- frame_done  out  1  One-cycle pulse: a frame completed.
- frame_drop  out  1  One-cycle pulse: a frame was abandoned.
- done_bank  out  1  Bank of the last complete frame.
- wr_err  out  1  Sticky write-response error (optional feature only).

Behaviour:
- Reset values: all outputs 0; awlen 0; state IDLE; wr_bank 0; beat_cnt 0.
- State IDLE:
  - On frame_start: beat_cnt <= 0, busy <= 1, go to WAIT_DATA.
  - wr_bank is 0 for the first frame after reset and toggles on every later frame_start.
- State WAIT_DATA: on fifo_rd_vld = 1, go to AW. This guarantees at least one word is ready before a burst is committed.
- Burst length: rem = FRAME_BEATS - beat_cnt; blen = min(BURST_LEN, rem).
- State AW:
  - awvalid = 1; awaddr = BASE_ADDR + wr_bank*BANK_STRIDE + beat_cnt*(DATA_W/8); awlen = blen-1.
  - awaddr and awlen are registered and held stable until the awvalid & awready handshake.
  - After the handshake, go to W with burst beat counter bcnt = 0.
- State W:
  - wvalid = fifo_rd_vld; wdata = fifo_rd_data; wstrb all ones; wlast = (bcnt == blen-1).
  - fifo_rd_en = wvalid & wready. A pop occurs only on an accepted beat, and data is never duplicated or skipped.
  - wvalid may drop mid-burst while the FIFO is empty; this is legal AXI.
  - Each accepted beat: bcnt++, beat_cnt++.
  - After the accepted wlast beat, go to B.
- State B:
  - bready = 1. On bvalid, check in order:
  - (a) If a restart is pending: pulse frame_drop, clear pending, toggle wr_bank, beat_cnt <= 0, go to WAIT_DATA.
  - (b) Else if beat_cnt == FRAME_BEATS: pulse frame_done, done_bank <= wr_bank, busy <= 0, go to IDLE.
  - (c) Else go to WAIT_DATA.
- frame_start while not IDLE:
  - Sets restart_pend; the in-flight AXI burst always completes (bursts are never aborted).
  - A frame_start arriving in the same cycle that B exits to IDLE is taken as a normal new-frame start in the following cycle. It is never lost.
- The final partial burst uses awlen = rem-1 (e.g. 2 beats gives awlen = 1).
- A single outstanding transaction only; AW is never issued before the previous B.
- beat_cnt is ceil(log2(FRAME_BEATS+1)) bits wide; the address product is truncated to ADDR_W.
- rd_rst asserted mid-burst: immediate return to reset values. The AXI slave and FIFO are reset by the same rd_rst.

Optional Feature:
- Macro: DDR_WR_BRESP_CHK_EN.
- Defined:
  - Any bresp != 2'b00 sets wr_err (sticky until rd_rst).
  - A frame with an error burst ends with frame_drop instead of frame_done; done_bank is not updated.
- Undefined:
  - bresp is ignored and wr_err is tied to 0.

Test Plan:
- BURST_LEN=4, FRAME_BEATS=10, FIFO always valid, slave always ready, one frame_start -> AW at 0x00/awlen 3, 0x40/awlen 3, 0x80/awlen 1; 10 pops; frame_done pulse; done_bank=0.
- Same configuration, second frame_start after done -> addresses BANK_STRIDE+0x00/+0x40/+0x80; done_bank=1.
- fifo_rd_vld toggling 1/0 every cycle, wready low 3 cycles mid-burst -> wvalid follows vld; no pop without wready; beat data sequence 0..9 written in order exactly once.
- frame_start pulsed during the second burst -> that burst completes with wlast and B, then frame_drop pulse, bank toggles, next AW at the other bank base, no frame_done.
- rd_rst asserted in W state after 2 beats -> all outputs 0 next cycle; a fresh frame_start restarts at bank 0, address 0x00.
- DDR_WR_BRESP_CHK_EN defined, bresp=2'b10 on the second burst -> wr_err=1 and stays 1; frame ends with frame_drop; done_bank unchanged.

Source files
------------

// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the prefetch FIFO into single-outstanding AXI write bursts, ping-ponging frames between two DDR banks.
// Optional write-response checking is enabled by defining DDR_WR_BRESP_CHK_EN.
module ddr_wr_burst_ctrl #(
    parameter int                ADDR_W      = 28,
    parameter int                DATA_W      = 128,
    parameter int                BURST_LEN   = 16,
    parameter int                FRAME_BEATS = 98304,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = ADDR_W'('h0200000)
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                frame_start,
    input  logic                fifo_rd_vld,
    input  logic [DATA_W-1:0]   fifo_rd_data,
    output logic                fifo_rd_en,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_drop,
    output logic                done_bank,
    output logic                wr_err
);
    localparam int CNT_W  = $clog2(FRAME_BEATS + 1);
    localparam int LEN_W  = (CNT_W > 9) ? CNT_W : 9;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, AW, W, B} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [7:0]        bcnt;
    logic              wr_bank;
    logic              first_frame;
    logic              restart_pend;
    logic              in_w;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  blen;
    logic [ADDR_W-1:0] next_awaddr;
    logic [7:0]        next_awlen;
    logic              bad_resp;

    assign rem         = LEN_W'(FRAME_BEATS) - LEN_W'(beat_cnt);
    assign blen        = (rem < LEN_W'(BURST_LEN)) ? rem : LEN_W'(BURST_LEN);
    assign next_awlen  = 8'(blen - 1'b1);
    assign next_awaddr = BASE_ADDR + (wr_bank ? BANK_STRIDE : '0)
                       + ADDR_W'(beat_cnt) * ADDR_W'(STRB_W);

    // The W channel is a direct window onto the FIFO head so nothing is popped unless the slave took it.
    assign m_wvalid   = in_w & fifo_rd_vld;
    assign m_wdata    = in_w ? fifo_rd_data : '0;
    assign m_wstrb    = in_w ? '1 : '0;
    assign m_wlast    = in_w & (bcnt == m_awlen);
    assign fifo_rd_en = m_wvalid & m_wready;

`ifdef DDR_WR_BRESP_CHK_EN
    logic frame_err;
    assign bad_resp = (m_bresp != 2'b00);
`else
    logic unused_bresp;
    assign unused_bresp = ^m_bresp;
    assign bad_resp     = 1'b0;
    assign wr_err       = 1'b0;
`endif

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            bcnt         <= '0;
            wr_bank      <= 1'b0;
            first_frame  <= 1'b1;
            restart_pend <= 1'b0;
            in_w         <= 1'b0;
            m_awaddr     <= '0;
            m_awlen      <= '0;
            m_awvalid    <= 1'b0;
            m_bready     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_drop   <= 1'b0;
            done_bank    <= 1'b0;
`ifdef DDR_WR_BRESP_CHK_EN
            frame_err    <= 1'b0;
            wr_err       <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            // A start seen outside IDLE is remembered; IDLE also consumes it so a start on the B->IDLE cycle is kept.
            if (frame_start && state != IDLE)
                restart_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start || restart_pend) begin
                        restart_pend <= 1'b0;
                        beat_cnt     <= '0;
                        busy         <= 1'b1;
                        first_frame  <= 1'b0;
                        if (!first_frame)
                            wr_bank <= ~wr_bank;
`ifdef DDR_WR_BRESP_CHK_EN
                        frame_err <= 1'b0;
`endif
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (fifo_rd_vld) begin
                        m_awaddr  <= next_awaddr;
                        m_awlen   <= next_awlen;
                        m_awvalid <= 1'b1;
                        state     <= AW;
                    end
                end
                AW: begin
                    if (m_awready) begin
                        m_awvalid <= 1'b0;
                        bcnt      <= '0;
                        in_w      <= 1'b1;
                        state     <= W;
                    end
                end
                W: begin
                    if (fifo_rd_en) begin
                        bcnt     <= bcnt + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_wlast) begin
                            in_w     <= 1'b0;
                            m_bready <= 1'b1;
                            state    <= B;
                        end
                    end
                end
                B: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
`ifdef DDR_WR_BRESP_CHK_EN
                        if (bad_resp) begin
                            wr_err    <= 1'b1;
                            frame_err <= 1'b1;
                        end
`endif
                        if (restart_pend) begin
                            frame_drop   <= 1'b1;
                            restart_pend <= 1'b0;
                            wr_bank      <= ~wr_bank;
                            beat_cnt     <= '0;
`ifdef DDR_WR_BRESP_CHK_EN
                            frame_err    <= 1'b0;
`endif
                            state        <= WAIT_DATA;
                        end else if (beat_cnt == CNT_W'(FRAME_BEATS)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
`ifdef DDR_WR_BRESP_CHK_EN
                            if (frame_err || bad_resp) begin
                                frame_drop <= 1'b1;
                            end else begin
                                frame_done <= 1'b1;
                                done_bank  <= wr_bank;
                            end
`else
                            frame_done <= 1'b1;
                            done_bank  <= wr_bank;
`endif
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Directed + randomized bench for ddr_wr_burst_ctrl using a queue-based FIFO, AXI slave and frame model.
module tb_ddr_wr_burst_ctrl;
    localparam int          AW_W   = 28;
    localparam int          DW     = 128;
    localparam int          BL     = 4;
    localparam int          FB     = 10;
    localparam logic [27:0] BASE   = 28'h0;
    localparam logic [27:0] STRIDE = 28'h0200000;

    logic            rd_clk, rd_rst, frame_start, fifo_rd_vld, fifo_rd_en;
    logic [DW-1:0]   fifo_rd_data, m_wdata;
    logic [AW_W-1:0] m_awaddr;
    logic [7:0]      m_awlen;
    logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [DW/8-1:0] m_wstrb;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready, busy, frame_done, frame_drop, done_bank, wr_err;

    ddr_wr_burst_ctrl #(
        .ADDR_W(AW_W), .DATA_W(DW), .BURST_LEN(BL), .FRAME_BEATS(FB),
        .BASE_ADDR(BASE), .BANK_STRIDE(STRIDE)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start),
        .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop),
        .done_bank(done_bank), .wr_err(wr_err)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [27:0] addr;
        logic [7:0]  len;
    } aw_t;

    aw_t         aw_log[$];
    aw_t         exp_aw[$];
    logic [127:0] fifo_q[$];
    logic [127:0] w_log[$];
    logic [127:0] exp_w[$];

    int vectors = 0;
    int miscompares = 0;
    int vld_mode = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;
    int stall_at = 0;
    int err_burst = -1;
    int b_in_frame = 0;
    int beat_in_burst = 0;
    int proto_err = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    int drop_beats = 0;
    int exp_bank = 0;
    int last_done_bank = 0;
    bit first_frame_m = 1'b1;
    bit start_req = 1'b0;
    bit b_pend = 1'b0;
    bit outstanding = 1'b0;
    bit toggle = 1'b0;
    bit vld_gate;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the environment at the falling edge, observe handshakes just before the rising edge.
    task automatic tick();
        @(negedge rd_clk);
        frame_start = start_req;
        start_req   = 1'b0;
        toggle      = ~toggle;
        case (vld_mode)
            0:       vld_gate = 1'b1;
            1:       vld_gate = toggle;
            default: vld_gate = 1'($urandom_range(0, 1));
        endcase
        fifo_rd_vld  = vld_gate && (fifo_q.size() > 0);
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (stall_cnt > 0) begin
            m_wready = 1'b0;
            stall_cnt--;
        end else begin
            m_wready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        m_awready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        m_bvalid  = b_pend;
        m_bresp   = (b_pend && b_in_frame == err_burst) ? 2'b10 : 2'b00;
        #4;
        if (m_awvalid && m_awready) begin
            if (outstanding) proto_err++;
            outstanding = 1'b1;
            aw_log.push_back({m_awaddr, m_awlen});
            beat_in_burst = 0;
        end
        if (fifo_rd_en !== (m_wvalid && m_wready)) proto_err++;
        if (m_wvalid && !fifo_rd_vld) proto_err++;
        if (m_wvalid && m_wready) begin
            if (m_wstrb !== '1) proto_err++;
            if (aw_log.size() == 0 || m_wlast !== (beat_in_burst == int'(aw_log[aw_log.size()-1].len)))
                proto_err++;
            w_log.push_back(m_wdata);
            beat_in_burst++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            else proto_err++;
            if (m_wlast) b_pend = 1'b1;
            if (stall_at > 0 && w_log.size() == stall_at) begin
                stall_cnt = 3;
                stall_at  = 0;
            end
        end
        if (m_bvalid && m_bready) begin
            b_pend      = 1'b0;
            outstanding = 1'b0;
            b_in_frame++;
        end
        if (frame_done) done_cnt++;
        if (frame_drop) begin
            drop_cnt++;
            drop_beats = w_log.size();
        end
    endtask

    task automatic push_aw(input int bank, input int off);
        aw_t e;
        e.addr = BASE + (bank != 0 ? STRIDE : 28'h0) + 28'(off * (DW / 8));
        e.len  = 8'((((FB - off) < BL) ? (FB - off) : BL) - 1);
        exp_aw.push_back(e);
    endtask

    task automatic expect_frame(input int bank);
        for (int off = 0; off < FB; off += BL) push_aw(bank, off);
    endtask

    task automatic push_words(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fifo_q.push_back(w);
            exp_w.push_back(w);
        end
    endtask

    task automatic start_frame(input bit full);
        start_req     = 1'b1;
        b_in_frame    = 0;
        exp_bank      = first_frame_m ? 0 : 1 - exp_bank;
        first_frame_m = 1'b0;
        if (full) expect_frame(exp_bank);
    endtask

    task automatic run_until_end(input string tag, input int budget);
        int d0 = done_cnt;
        int r0 = drop_cnt;
        int n = 0;
        while (done_cnt == d0 && drop_cnt == r0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_in_time"}, 128'(n < budget), 128'(1));
    endtask

    task automatic check_log(input string tag);
        check({tag, "_aw_count"}, 128'(aw_log.size()), 128'(exp_aw.size()));
        for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) begin
            check($sformatf("%s_awaddr%0d", tag, i), 128'(aw_log[i].addr), 128'(exp_aw[i].addr));
            check($sformatf("%s_awlen%0d", tag, i), 128'(aw_log[i].len), 128'(exp_aw[i].len));
        end
        check({tag, "_beat_count"}, 128'(w_log.size()), 128'(exp_w.size()));
        for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
            check($sformatf("%s_wdata%0d", tag, i), w_log[i], exp_w[i]);
        check({tag, "_protocol"}, 128'(proto_err), 128'(0));
        aw_log.delete();
        exp_aw.delete();
        w_log.delete();
        exp_w.delete();
        proto_err = 0;
        done_cnt  = 0;
        drop_cnt  = 0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge rd_clk);
        rd_rst      = 1'b1;
        frame_start = 1'b0;
        #1;
        check({tag, "_ctl_zero"}, 128'({m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en,
                                         busy, frame_done, frame_drop, done_bank, wr_err}), 128'(0));
        check({tag, "_aw_zero"}, 128'({m_awaddr, m_awlen}), 128'(0));
        check({tag, "_w_zero"}, m_wdata, 128'(0));
        check({tag, "_wstrb_zero"}, 128'(m_wstrb), 128'(0));
        fifo_q.delete();
        aw_log.delete();
        exp_aw.delete();
        w_log.delete();
        exp_w.delete();
        b_pend        = 1'b0;
        outstanding   = 1'b0;
        first_frame_m = 1'b1;
        stall_cnt     = 0;
        stall_at      = 0;
        proto_err     = 0;
        done_cnt      = 0;
        drop_cnt      = 0;
        last_done_bank = 0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
    endtask

    initial begin
        int n;
        rd_rst = 1'b1; frame_start = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        apply_reset("reset");

        // Two back-to-back clean frames land in bank 0 then bank 1.
        for (int f = 0; f < 2; f++) begin
            push_words(FB);
            start_frame(1'b1);
            run_until_end($sformatf("frame%0d", f), 200);
            repeat (3) tick();
            check($sformatf("frame%0d_done", f), 128'(done_cnt), 128'(1));
            check($sformatf("frame%0d_drop", f), 128'(drop_cnt), 128'(0));
            check($sformatf("frame%0d_bank", f), 128'(done_bank), 128'(exp_bank));
            check($sformatf("frame%0d_busy", f), 128'(busy), 128'(0));
            last_done_bank = exp_bank;
            check_log($sformatf("frame%0d", f));
        end

        // Bursty FIFO and a 3-cycle wready stall inside the second burst.
        vld_mode = 1;
        stall_at = 5;
        push_words(FB);
        start_frame(1'b1);
        run_until_end("gappy", 300);
        repeat (3) tick();
        check("gappy_done", 128'(done_cnt), 128'(1));
        check("gappy_bank", 128'(done_bank), 128'(exp_bank));
        last_done_bank = exp_bank;
        check_log("gappy");
        vld_mode = 0;

        // New frame_start during the second burst: burst finishes, frame dropped, other bank restarts.
        push_words(8 + FB);
        start_frame(1'b0);
        push_aw(exp_bank, 0);
        push_aw(exp_bank, BL);
        n = 0;
        while (aw_log.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("restart_second_aw", 128'(n < 100), 128'(1));
        start_req = 1'b1;
        run_until_end("restart_drop", 200);
        check("restart_drop_pulse", 128'(drop_cnt), 128'(1));
        check("restart_no_done", 128'(done_cnt), 128'(0));
        check("restart_drop_beats", 128'(drop_beats), 128'(2 * BL));
        exp_bank   = 1 - exp_bank;
        b_in_frame = 0;
        expect_frame(exp_bank);
        run_until_end("restart_frame", 200);
        repeat (3) tick();
        check("restart_done", 128'(done_cnt), 128'(1));
        check("restart_bank", 128'(done_bank), 128'(exp_bank));
        last_done_bank = exp_bank;
        check_log("restart");

        // Reset in the middle of a burst, then a fresh frame starts over at bank 0.
        push_words(FB);
        start_frame(1'b1);
        n = 0;
        while (w_log.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        check("midrst_two_beats", 128'(n < 100), 128'(1));
        apply_reset("midrst");
        push_words(FB);
        start_frame(1'b1);
        run_until_end("after_rst", 200);
        repeat (3) tick();
        check("after_rst_done", 128'(done_cnt), 128'(1));
        check("after_rst_bank", 128'(done_bank), 128'(0));
        last_done_bank = exp_bank;
        check_log("after_rst");

        // Random valid/ready throttling on both FIFO and slave.
        vld_mode = 2;
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            push_words(FB);
            start_frame(1'b1);
            run_until_end($sformatf("rand%0d", f), 600);
            repeat (3) tick();
            check($sformatf("rand%0d_done", f), 128'(done_cnt), 128'(1));
            check($sformatf("rand%0d_bank", f), 128'(done_bank), 128'(exp_bank));
            last_done_bank = exp_bank;
            check_log($sformatf("rand%0d", f));
        end
        vld_mode = 0;
        rdy_mode = 0;

        // SLVERR on the second burst of a frame.
        err_burst = 1;
        push_words(FB);
        start_frame(1'b1);
        run_until_end("bresp", 200);
        repeat (3) tick();
`ifdef DDR_WR_BRESP_CHK_EN
        check("bresp_drop", 128'(drop_cnt), 128'(1));
        check("bresp_no_done", 128'(done_cnt), 128'(0));
        check("bresp_bank_kept", 128'(done_bank), 128'(last_done_bank));
        check("bresp_wr_err", 128'(wr_err), 128'(1));
        check_log("bresp");
        err_burst = -1;
        push_words(FB);
        start_frame(1'b1);
        run_until_end("post_err", 200);
        repeat (3) tick();
        check("post_err_done", 128'(done_cnt), 128'(1));
        check("post_err_sticky", 128'(wr_err), 128'(1));
        check_log("post_err");
`else
        check("bresp_done", 128'(done_cnt), 128'(1));
        check("bresp_no_drop", 128'(drop_cnt), 128'(0));
        check("bresp_bank", 128'(done_bank), 128'(exp_bank));
        check("bresp_wr_err", 128'(wr_err), 128'(0));
        check_log("bresp");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
